// File: rtl/vga_pkg.sv
// Shared VGA timing constants, colours and enums for the timing stage and
// the pixel-colour stage.
package vga_pkg;

    localparam int HVALID = 640;
    localparam int VVALID = 480;
    localparam int HMAX   = 800;
    localparam int VMAX   = 521;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t COL_RED   = '{r: 4'hF, g: 4'h0, b: 4'h0};
    localparam rgb_t COL_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        DIV     = 2'd1,
        UPD_X   = 2'd2,
        UPD_Y   = 2'd3
    } upd_state_t;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

endpackage

// File: rtl/vga_box_renderer_if.sv
// Timing-stage to renderer bundle: counters/syncs in, registered VGA pins out.
interface vga_box_renderer_if;
    logic       PIX_EN;
    logic [9:0] HCNT;
    logic [9:0] VCNT;
    logic       HS_IN;
    logic       VS_IN;
    logic       PAUSE;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;

    modport master (
        output PIX_EN, HCNT, VCNT, HS_IN, VS_IN, PAUSE,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );

    modport slave (
        input  PIX_EN, HCNT, VCNT, HS_IN, VS_IN, PAUSE,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );
endinterface

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing box: position and direction, clamped to
// 0..limit and reflected when an edge is reached.
module vga_bounce_axis
    import vga_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       upd,
    input  logic [9:0] step,
    input  logic [9:0] limit,
    output logic [9:0] pos
);

    dir_t        dir;
    logic [10:0] sum;

    // 11-bit sum so pos+step can never wrap before the limit compare
    assign sum = {1'b0, pos} + {1'b0, step};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pos <= '0;
            dir <= DIR_POS;
        end else if (upd) begin
            if (dir == DIR_POS) begin
                if (sum >= {1'b0, limit}) begin
                    pos <= limit;
                    dir <= DIR_NEG;
                end else begin
                    pos <= sum[9:0];
                end
            end else begin
                if ({1'b0, pos} <= {1'b0, step}) begin
                    pos <= '0;
                    dir <= DIR_POS;
                end else begin
                    pos <= pos - step;
                end
            end
        end
    end

endmodule

// File: rtl/vga_box_renderer.sv
// Bouncing-box pixel stage: one registered PIX_EN stage for colour and syncs,
// position updated in vblank. Optional white border: VGA_BOX_BORDER_EN.
module vga_box_renderer #(
    parameter int HVALID    = vga_pkg::HVALID,
    parameter int VVALID    = vga_pkg::VVALID,
    parameter int BOX_W     = 320,
    parameter int BOX_H     = 120,
    parameter int STEP_X    = 10,
    parameter int STEP_Y    = 8,
    parameter int FRAME_DIV = 2
) (
    input logic               CLK,
    input logic               RST_N,
    vga_box_renderer_if.slave vif
);
    import vga_pkg::*;

    upd_state_t state_q, state_d;
    logic [3:0] div_q, div_d;
    logic       vs_prev, vs_fall;
    logic       upd_x, upd_y;
    logic [9:0] x_pos, y_pos;
    rgb_t       pix_d, pix_q;
    logic       hs_q, vs_q;

    vga_bounce_axis u_x (
        .CLK   (CLK),
        .RST_N (RST_N),
        .upd   (upd_x),
        .step  (10'(STEP_X)),
        .limit (10'(HVALID - BOX_W)),
        .pos   (x_pos)
    );

    vga_bounce_axis u_y (
        .CLK   (CLK),
        .RST_N (RST_N),
        .upd   (upd_y),
        .step  (10'(STEP_Y)),
        .limit (10'(VVALID - BOX_H)),
        .pos   (y_pos)
    );

    assign vs_fall = vif.PIX_EN && vs_prev && !vif.VS_IN;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= WAIT_VS;
            div_q   <= '0;
            vs_prev <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            if (vif.PIX_EN) vs_prev <= vif.VS_IN;
        end
    end

    // PAUSE is only looked at here, so a started update always finishes
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        upd_x   = 1'b0;
        upd_y   = 1'b0;
        case (state_q)
            WAIT_VS: if (vs_fall && !vif.PAUSE) state_d = DIV;
            DIV: begin
                if (div_q == 4'(FRAME_DIV - 1)) begin
                    div_d   = '0;
                    state_d = UPD_X;
                end else begin
                    div_d   = div_q + 4'd1;
                    state_d = WAIT_VS;
                end
            end
            UPD_X: begin
                upd_x   = 1'b1;
                state_d = UPD_Y;
            end
            UPD_Y: begin
                upd_y   = 1'b1;
                state_d = WAIT_VS;
            end
            default: state_d = WAIT_VS;
        endcase
    end

    logic [10:0] h11, v11, x11, y11;
    logic        active, in_box;

    assign h11 = {1'b0, vif.HCNT};
    assign v11 = {1'b0, vif.VCNT};
    assign x11 = {1'b0, x_pos};
    assign y11 = {1'b0, y_pos};

    assign active = (vif.HCNT < 10'(HVALID)) && (vif.VCNT < 10'(VVALID));
    assign in_box = (h11 >= x11) && (h11 < x11 + 11'(BOX_W)) &&
                    (v11 >= y11) && (v11 < y11 + 11'(BOX_H));

`ifdef VGA_BOX_BORDER_EN
    logic on_edge;
    assign on_edge = (h11 < x11 + 11'd2) || (h11 >= x11 + 11'(BOX_W - 2)) ||
                     (v11 < y11 + 11'd2) || (v11 >= y11 + 11'(BOX_H - 2));
`endif

    always_comb begin
        pix_d = COL_BLACK;
        if (active) begin
            if (in_box) begin
                pix_d = '{r: vif.VCNT[3:0], g: 4'h0, b: 4'hF};
`ifdef VGA_BOX_BORDER_EN
                if (on_edge) pix_d = '{r: 4'hF, g: 4'hF, b: 4'hF};
`endif
            end else begin
                pix_d = COL_RED;
            end
        end
    end

    // colour and syncs share this stage so they stay aligned on the pins
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pix_q <= COL_BLACK;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else if (vif.PIX_EN) begin
            pix_q <= pix_d;
            hs_q  <= vif.HS_IN;
            vs_q  <= vif.VS_IN;
        end
    end

    assign vif.VGA_R  = pix_q.r;
    assign vif.VGA_G  = pix_q.g;
    assign vif.VGA_B  = pix_q.b;
    assign vif.VGA_HS = hs_q;
    assign vif.VGA_VS = vs_q;

endmodule
